// File: rtl/mux8_arb_pkg.sv
`default_nettype none
// mux8_arb_pkg: shared state type, data width and burst default for mux8_rr_arbiter.
// Rev 1.0
package mux8_arb_pkg;
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int DW            = 8;
  localparam int BURST_MAX_DEF = 4;
  localparam int CNT_W         = 4;
endpackage
`default_nettype wire

// File: rtl/MUX_8bit.sv
`default_nettype none
// MUX_8bit: 8-bit 2:1 multiplexer, signal = 0 selects In1, signal = 1 selects In2.
// Rev 1.0
module MUX_8bit (
  input  logic [7:0] In1,
  input  logic [7:0] In2,
  input  logic       signal,
  output logic [7:0] out
);
  assign out = signal ? In2 : In1;
endmodule
`default_nettype wire

// File: rtl/mux8_rr_arbiter.sv
`default_nettype none
// mux8_rr_arbiter: two-requester round-robin burst arbiter feeding one registered 8-bit output.
// Rev 1.0
module mux8_rr_arbiter #(
  parameter int BURST_MAX = mux8_arb_pkg::BURST_MAX_DEF,
  parameter int DW        = mux8_arb_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [DW-1:0] data0,
  input  logic          req1,
  input  logic [DW-1:0] data1,
  output logic          ack0,
  output logic          ack1,
  output logic          sel,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);
  import mux8_arb_pkg::*;

  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);

  state_t             state, state_nxt;
  logic               sel_nxt;
  logic               last, last_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_inc;
  logic [DW-1:0]      out_data_nxt;
  logic               out_valid_nxt;
  logic [DW-1:0]      mux_data;
  logic               req_sel;
  logic               load_opp;

  MUX_8bit u_mux (
    .In1    (data0),
    .In2    (data1),
    .signal (sel),
    .out    (mux_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= 1'b0;
      last      <= 1'b1;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      sel       <= sel_nxt;
      last      <= last_nxt;
      cnt       <= cnt_nxt;
      out_data  <= out_data_nxt;
      out_valid <= out_valid_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    sel_nxt       = sel;
    last_nxt      = last;
    cnt_nxt       = cnt;
    out_data_nxt  = out_data;
    out_valid_nxt = out_valid;
    ack0          = 1'b0;
    ack1          = 1'b0;
    busy          = (state == GRANT);
    req_sel       = sel ? req1 : req0;
    load_opp      = !out_valid || out_ready;
    cnt_inc       = cnt + 1'b1;

    case (state)
      IDLE: begin
        // the last beat of the previous burst may still be draining here
        if (out_ready) out_valid_nxt = 1'b0;
        if (req0 || req1) begin
          state_nxt = GRANT;
          cnt_nxt   = '0;
          sel_nxt   = (req0 && req1) ? ~last : req1;
        end
      end
      GRANT: begin
        if (load_opp) begin
          if (req_sel) begin
            out_data_nxt  = mux_data;
            out_valid_nxt = 1'b1;
            ack0          = !sel;
            ack1          = sel;
            cnt_nxt       = cnt_inc;
            if (cnt_inc == BURST_LIM) begin
              state_nxt = IDLE;
              last_nxt  = sel;
            end
          end else begin
            out_valid_nxt = 1'b0;
            state_nxt     = IDLE;
            last_nxt      = sel;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule
`default_nettype wire

// File: tb/tb_mux8_rr_arbiter.sv
`default_nettype none
// tb_mux8_rr_arbiter: directed and randomized checks of mux8_rr_arbiter against a transaction-level model.
module tb_mux8_rr_arbiter;
  localparam int BURST = 4;

  logic       clk = 1'b0;
  logic       rst, req0, req1, out_ready;
  logic [7:0] data0, data1, out_data;
  logic       ack0, ack1, sel, out_valid, busy;

  mux8_rr_arbiter #(.BURST_MAX(BURST), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .ack0(ack0), .ack1(ack1), .sel(sel),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;

  // requester beat queues; head is the beat currently presented
  logic [7:0] q0[$], q1[$];
  bit en0, en1;

  // model: grant owner, beats in this grant, last served, output slot
  bit         m_busy, m_sel, m_ov, m_last;
  logic [7:0] m_od;
  int         m_beats;
  bit         e_ack0, e_ack1;
  logic [7:0] acc_q[$];
  int         ack_q[$];
  int         ack_cyc[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_sel = 0; m_ov = 0; m_last = 1; m_od = 8'h00; m_beats = 0;
    acc_q.delete(); ack_q.delete(); ack_cyc.delete();
  endtask

  task automatic drive();
    req0  = en0 && (q0.size() > 0);
    data0 = (q0.size() > 0) ? q0[0] : 8'h00;
    req1  = en1 && (q1.size() > 0);
    data1 = (q1.size() > 0) ? q1[0] : 8'h00;
  endtask

  // called at the falling edge: drive, settle, compare all outputs
  task automatic tick_pre();
    bit can, rs;
    drive();
    #1;
    can    = m_busy && (!m_ov || out_ready);
    rs     = m_sel ? req1 : req0;
    e_ack0 = can && rs && !m_sel;
    e_ack1 = can && rs && m_sel;
    check("busy",      busy,      m_busy);
    check("sel",       sel,       m_sel);
    check("out_valid", out_valid, m_ov);
    check("out_data",  out_data,  m_od);
    check("ack0",      ack0,      e_ack0);
    check("ack1",      ack1,      e_ack1);
  endtask

  task automatic tick_post();
    bit r0, r1, rs, can;
    r0 = req0; r1 = req1;
    if (m_ov && out_ready) acc_q.push_back(m_od);
    if (m_busy) begin
      rs  = m_sel ? r1 : r0;
      can = !m_ov || out_ready;
      if (can && rs) begin
        if (m_sel) m_od = q1.pop_front();
        else       m_od = q0.pop_front();
        ack_q.push_back(int'(m_sel));
        ack_cyc.push_back(cyc);
        m_ov = 1;
        m_beats++;
        if (m_beats == BURST) begin m_busy = 0; m_last = m_sel; end
      end else if (can) begin
        m_ov = 0; m_busy = 0; m_last = m_sel;
      end
    end else begin
      if (out_ready) m_ov = 0;
      if (r0 || r1) begin
        m_busy  = 1;
        m_beats = 0;
        m_sel   = (r0 && r1) ? !m_last : r1;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(int n);
    repeat (n) begin tick_pre(); tick_post(); end
  endtask

  // reset rises mid-cycle; outputs must clear before any clock edge
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_busy",      busy,      0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data,  0);
    check("rst_sel",       sel,       0);
    check("rst_ack0",      ack0,      0);
    check("rst_ack1",      ack1,      0);
    model_reset();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_stim();
    q0.delete(); q1.delete(); en0 = 0; en1 = 0; out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int s, i;
    rst = 1'b1; out_ready = 1'b1; en0 = 0; en1 = 0;
    model_reset();
    drive();
    #1;
    check("init_busy",      busy,      0);
    check("init_out_valid", out_valid, 0);
    check("init_sel",       sel,       0);
    check("init_ack",       {ack0, ack1}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // single requester: A0..A5, one idle cycle between bursts
    clear_stim();
    for (int k = 0; k < 6; k++) q0.push_back(8'hA0 + 8'(k));
    en0 = 1; s = cyc;
    run(16);
    check("single_count", acc_q.size(), 6);
    for (int k = 0; k < acc_q.size() && k < 6; k++) check("single_data", acc_q[k], 32'hA0 + k);
    for (int k = 0; k < ack_q.size(); k++) check("single_sel", ack_q[k], 0);
    if (ack_cyc.size() >= 5) begin
      check("single_latency", ack_cyc[0] - s, 1);
      check("single_back2back", ack_cyc[1] - ack_cyc[0], 1);
      check("single_idle_gap", ack_cyc[4] - ack_cyc[3], 2);
    end else check("single_acks", ack_cyc.size(), 6);

    // tie after reset: strictly alternating bursts, requester 0 first
    clear_stim(); async_reset();
    for (int k = 0; k < 16; k++) begin
      q0.push_back(8'($urandom)); q1.push_back(8'($urandom));
    end
    en0 = 1; en1 = 1;
    for (i = 0; i < 200 && (q0.size() > 0 || q1.size() > 0); i++) run(1);
    check("tie_timeout", (q0.size() + q1.size()), 0);
    run(3);
    check("tie_count", ack_q.size(), 32);
    for (int k = 0; k < ack_q.size(); k++) check("tie_order", ack_q[k], (k / 4) % 2);

    // back-pressure after first beat 5A
    clear_stim(); async_reset();
    q0 = '{8'h5A, 8'h5B, 8'h5C};
    en0 = 1;
    for (i = 0; i < 10 && !m_ov; i++) run(1);
    check("bp_first_load", m_ov, 1);
    out_ready = 1'b0;
    repeat (3) begin
      tick_pre();
      check("bp_hold_data", m_od, 8'h5A);
      check("bp_no_ack", e_ack0, 0);
      tick_post();
    end
    out_ready = 1'b1;
    run(10);
    check("bp_count", acc_q.size(), 3);
    for (int k = 0; k < acc_q.size() && k < 3; k++) check("bp_data", acc_q[k], 32'h5A + k);

    // mid-burst drop of req1, pending req0 granted next
    clear_stim(); async_reset();
    q1 = '{8'h11, 8'h22, 8'h33, 8'h44};
    q0 = '{8'h77};
    en1 = 1;
    run(1);
    en0 = 1;
    for (i = 0; i < 10 && ack_q.size() < 2; i++) run(1);
    en1 = 0;
    run(8);
    check("drop_acks", ack_q.size(), 3);
    if (ack_q.size() == 3) begin
      check("drop_ack_a", ack_q[0], 1);
      check("drop_ack_b", ack_q[1], 1);
      check("drop_ack_c", ack_q[2], 0);
    end
    if (acc_q.size() == 3) begin
      check("drop_data_a", acc_q[0], 8'h11);
      check("drop_data_b", acc_q[1], 8'h22);
      check("drop_data_c", acc_q[2], 8'h77);
    end else check("drop_beats", acc_q.size(), 3);

    // reset pulsed while beat 3 is being acknowledged
    clear_stim(); async_reset();
    for (int k = 0; k < 6; k++) q0.push_back(8'hC0 + 8'(k));
    en0 = 1;
    for (i = 0; i < 10 && ack_q.size() < 2; i++) run(1);
    tick_pre();
    check("mr_beat3_ack", e_ack0, 1);
    async_reset();
    q1 = '{8'hD0, 8'hD1};
    en1 = 1;
    run(4);
    check("mr_first_grant", (ack_q.size() > 0) ? ack_q[0] : 9, 0);
    check("mr_no_lost_beat", (acc_q.size() > 0) ? acc_q[0] : 8'hFF, 8'hC2);

    // randomized traffic
    clear_stim(); async_reset();
    en0 = 1; en1 = 1;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 7) == 0) en0 = ~en0;
      if ($urandom_range(0, 7) == 0) en1 = ~en1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (q0.size() < 3 && $urandom_range(0, 1) == 1) q0.push_back(8'($urandom));
      if (q1.size() < 3 && $urandom_range(0, 1) == 1) q1.push_back(8'($urandom));
      tick_pre();
      if (k == 300) async_reset();
      else tick_post();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
